// File: rtl/gnrl_ltch_wrctl.sv
// Write-port sequencer for a latch-based register file: valid/ready intake, staged data bus,
// and a flop-sourced one-hot latch enable with a WRITE cycle followed by a HOLD cycle.
module gnrl_ltch_wrctl #(
   parameter int unsigned DW      = 32,
   parameter int unsigned NUM     = 32,
   parameter int unsigned AW      = 5,
   parameter bit          R0_ZERO = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_valid,
   output logic           i_ready,
   input  logic [AW-1:0]  i_addr,
   input  logic [DW-1:0]  i_data,
   output logic [NUM-1:0] o_lden,
   output logic [DW-1:0]  o_dnxt,
   output logic           o_busy,
   output logic           o_wr_err
);

   typedef enum logic [1:0] {StIdle, StWrite, StHold} state_e;

   state_e         state_q, state_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [DW-1:0]  dnxt_q, dnxt_d;
   logic [NUM-1:0] lden_q, lden_d;
   logic           wr_err_q, wr_err_d;

   logic accept;
   logic addr_in_range;
   logic addr_writable;

   assign i_ready       = (state_q != StWrite);
   assign o_busy        = (state_q != StIdle);
   assign accept        = i_valid & i_ready;
   assign addr_in_range = (32'(i_addr) < NUM);
   assign addr_writable = addr_in_range && !(R0_ZERO && (i_addr == '0));

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      dnxt_d   = dnxt_q;
      lden_d   = '0;
      wr_err_d = 1'b0;

      unique case (state_q)
         StIdle:  if (accept) state_d = StWrite;
         StWrite: state_d = StHold;
         StHold:  state_d = accept ? StWrite : StIdle;
         default: state_d = StIdle;
      endcase

      // Enable is decoded at accept so it is a clean flop output for the whole WRITE cycle.
      if (accept) begin
         addr_d   = i_addr;
         dnxt_d   = i_data;
         wr_err_d = !addr_in_range;
         for (int unsigned k = 0; k < NUM; k++) begin
            lden_d[k] = addr_writable && (32'(i_addr) == k);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         dnxt_q   <= '0;
         lden_q   <= '0;
         wr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         dnxt_q   <= dnxt_d;
         lden_q   <= lden_d;
         wr_err_q <= wr_err_d;
      end
   end

   assign o_lden   = lden_q;
   assign o_dnxt   = dnxt_q;
   assign o_wr_err = wr_err_q;

   a_valid_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(i_valid))
      else $fatal(1, "i_valid is X out of reset");
   a_lden_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(o_lden))
      else $fatal(1, "o_lden is not onehot0");

endmodule

// File: tb/tb_gnrl_ltch_wrctl.sv
// Directed and scoreboard bench for gnrl_ltch_wrctl with NUM=31 and R0_ZERO=1.
module tb_gnrl_ltch_wrctl;

   localparam int unsigned DW  = 32;
   localparam int unsigned NUM = 31;
   localparam int unsigned AW  = 5;

   logic           clk;
   logic           rst_n;
   logic           i_valid;
   logic           i_ready;
   logic [AW-1:0]  i_addr;
   logic [DW-1:0]  i_data;
   logic [NUM-1:0] o_lden;
   logic [DW-1:0]  o_dnxt;
   logic           o_busy;
   logic           o_wr_err;

   int checks;
   int errors;

   gnrl_ltch_wrctl #(
      .DW      (DW),
      .NUM     (NUM),
      .AW      (AW),
      .R0_ZERO (1'b1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .i_addr   (i_addr),
      .i_data   (i_data),
      .o_lden   (o_lden),
      .o_dnxt   (o_dnxt),
      .o_busy   (o_busy),
      .o_wr_err (o_wr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [NUM-1:0] bit_of(input int a);
      logic [NUM-1:0] v;
      v = '0;
      if (a >= 0 && a < int'(NUM)) v[a] = 1'b1;
      return v;
   endfunction

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_addr  = '0;
      i_data  = '0;
      step();
      step();
      checks++;
      if (i_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b exp 1", i_ready);
      end
      checks++;
      if (o_busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %b exp 0", o_busy);
      end
      checks++;
      if (o_lden !== '0 || o_dnxt !== '0 || o_wr_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got lden=%h dnxt=%h err=%b exp 0/0/0",
                  o_lden, o_dnxt, o_wr_err);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_write();
      i_valid = 1'b1; i_addr = 5'd5; i_data = 32'hDEADBEEF;
      checks++;
      if (i_ready !== 1'b1) begin
         errors++; $display("FAIL t1_ready_idle got %b exp 1", i_ready);
      end
      step();
      i_valid = 1'b0; i_data = 32'h0;
      checks++;
      if (o_lden !== bit_of(5) || o_dnxt !== 32'hDEADBEEF || i_ready !== 1'b0) begin
         errors++;
         $display("FAIL t1_write got lden=%h dnxt=%h rdy=%b exp %h/deadbeef/0",
                  o_lden, o_dnxt, i_ready, bit_of(5));
      end
      step();
      checks++;
      if (o_lden !== '0 || o_dnxt !== 32'hDEADBEEF || i_ready !== 1'b1 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL t1_hold got lden=%h dnxt=%h rdy=%b busy=%b exp 0/deadbeef/1/1",
                  o_lden, o_dnxt, i_ready, o_busy);
      end
      step();
      checks++;
      if (o_busy !== 1'b0) begin
         errors++; $display("FAIL t1_idle got busy=%b exp 0", o_busy);
      end
   endtask

   task automatic test_back_to_back();
      int exp_rdy [7] = '{1, 0, 1, 0, 1, 0, 1};
      int exp_bit [7] = '{-1, 3, -1, 4, -1, 7, -1};
      for (int c = 0; c < 7; c++) begin
         checks++;
         if (i_ready !== exp_rdy[c][0] || o_lden !== bit_of(exp_bit[c])) begin
            errors++;
            $display("FAIL t2_cycle%0d got rdy=%b lden=%h exp rdy=%0d lden=%h",
                     c, i_ready, o_lden, exp_rdy[c], bit_of(exp_bit[c]));
         end
         checks++;
         if (!$onehot0(o_lden)) begin
            errors++; $display("FAIL t2_onehot cycle%0d got lden=%h exp onehot0", c, o_lden);
         end
         case (c)
            0: begin i_valid = 1'b1; i_addr = 5'd3; i_data = 32'h3333; end
            1: begin i_addr = 5'd4; i_data = 32'h4444; end
            3: begin i_addr = 5'd7; i_data = 32'h7777; end
            5: i_valid = 1'b0;
            default: ;
         endcase
         step();
      end
      checks++;
      if (o_busy !== 1'b0 || o_dnxt !== 32'h7777) begin
         errors++; $display("FAIL t2_end got busy=%b dnxt=%h exp 0/7777", o_busy, o_dnxt);
      end
   endtask

   task automatic test_addr_zero();
      i_valid = 1'b1; i_addr = 5'd0; i_data = 32'h1;
      checks++;
      if (i_ready !== 1'b1) begin
         errors++; $display("FAIL t3_ready got %b exp 1", i_ready);
      end
      step();
      i_valid = 1'b0;
      checks++;
      if (o_lden !== '0 || o_wr_err !== 1'b0 || o_busy !== 1'b1 || o_dnxt !== 32'h1) begin
         errors++;
         $display("FAIL t3_write got lden=%h err=%b busy=%b dnxt=%h exp 0/0/1/1",
                  o_lden, o_wr_err, o_busy, o_dnxt);
      end
      step();
      checks++;
      if (o_lden !== '0 || o_wr_err !== 1'b0) begin
         errors++; $display("FAIL t3_hold got lden=%h err=%b exp 0/0", o_lden, o_wr_err);
      end
      step();
   endtask

   task automatic test_out_of_range();
      i_valid = 1'b1; i_addr = 5'd31; i_data = 32'h55;
      checks++;
      if (o_wr_err !== 1'b0) begin
         errors++; $display("FAIL t4_pre_err got %b exp 0", o_wr_err);
      end
      step();
      i_valid = 1'b0;
      checks++;
      if (o_lden !== '0 || o_wr_err !== 1'b1) begin
         errors++; $display("FAIL t4_write got lden=%h err=%b exp 0/1", o_lden, o_wr_err);
      end
      step();
      checks++;
      if (o_lden !== '0 || o_wr_err !== 1'b0) begin
         errors++; $display("FAIL t4_hold got lden=%h err=%b exp 0/0", o_lden, o_wr_err);
      end
      step();
      checks++;
      if (o_busy !== 1'b0) begin
         errors++; $display("FAIL t4_idle got busy=%b exp 0", o_busy);
      end
   endtask

   task automatic test_reset_mid_write();
      i_valid = 1'b1; i_addr = 5'd9; i_data = 32'h9999;
      step();
      i_valid = 1'b0;
      checks++;
      if (o_lden !== bit_of(9)) begin
         errors++; $display("FAIL t5_write got lden=%h exp %h", o_lden, bit_of(9));
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (o_lden !== '0 || o_busy !== 1'b0 || o_dnxt !== '0) begin
         errors++;
         $display("FAIL t5_async got lden=%h busy=%b dnxt=%h exp 0/0/0", o_lden, o_busy, o_dnxt);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (i_ready !== 1'b1 || o_busy !== 1'b0 || o_lden !== '0) begin
         errors++;
         $display("FAIL t5_release got rdy=%b busy=%b lden=%h exp 1/0/0", i_ready, o_busy, o_lden);
      end
   endtask

   task automatic test_scoreboard();
      logic [DW-1:0]  arr [NUM];
      logic [DW-1:0]  ref_mem [NUM];
      logic [NUM-1:0] exp_lden, prev_lden;
      logic [DW-1:0]  prev_dnxt;
      logic           exp_err, pend, acc;
      int             exp_state; // 0 idle, 1 write, 2 hold
      int             nwr, drain, cyc, a;
      for (int k = 0; k < int'(NUM); k++) begin
         arr[k] = '0; ref_mem[k] = '0;
      end
      exp_lden = '0; prev_lden = '0; prev_dnxt = o_dnxt; exp_err = 1'b0;
      exp_state = 0; pend = 1'b0; nwr = 0; drain = 0; cyc = 0;
      while (drain < 4 && cyc < 20000) begin
         for (int k = 0; k < int'(NUM); k++) if (o_lden[k]) arr[k] = o_dnxt;
         if (prev_lden != '0 && o_lden === '0 && o_dnxt !== prev_dnxt) begin
            errors++; $display("FAIL t6_dnxt_stable got %h exp %h", o_dnxt, prev_dnxt);
         end
         checks++;
         if (i_ready !== (exp_state != 1) || o_lden !== exp_lden || o_wr_err !== exp_err) begin
            errors++;
            $display("FAIL t6_cycle%0d got rdy=%b lden=%h err=%b exp rdy=%b lden=%h err=%b",
                     cyc, i_ready, o_lden, o_wr_err, exp_state != 1, exp_lden, exp_err);
         end
         prev_lden = o_lden;
         prev_dnxt = o_dnxt;
         if (!pend && nwr < 1000 && $urandom_range(0, 2) != 0) begin
            pend   = 1'b1;
            i_addr = AW'($urandom_range(0, 31));
            i_data = $urandom;
         end
         if (nwr >= 1000) drain++;
         i_valid = pend;
         acc = pend && (exp_state != 1);
         a = int'(i_addr);
         exp_lden = '0;
         exp_err  = 1'b0;
         if (acc) begin
            if (a != 0 && a < int'(NUM)) begin
               ref_mem[a] = i_data;
               exp_lden = bit_of(a);
            end
            exp_err = (a >= int'(NUM));
            pend = 1'b0;
            nwr++;
         end
         case (exp_state)
            0: exp_state = acc ? 1 : 0;
            1: exp_state = 2;
            default: exp_state = acc ? 1 : 0;
         endcase
         step();
         cyc++;
      end
      i_valid = 1'b0;
      checks++;
      if (nwr < 1000) begin
         errors++; $display("FAIL t6_budget got %0d writes exp 1000", nwr);
      end
      for (int k = 0; k < int'(NUM); k++) begin
         checks++;
         if (arr[k] !== ref_mem[k]) begin
            errors++; $display("FAIL t6_entry%0d got %h exp %h", k, arr[k], ref_mem[k]);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_write();
      test_back_to_back();
      test_addr_zero();
      test_out_of_range();
      test_reset_mid_write();
      test_scoreboard();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
